// File: rtl/beam_meta_window_builder.sv
// Accumulates beam triggers over a WINDOW-cycle window, maps them onto NMETA bits through
// programmable masks and queues the results in a FWFT FIFO. Option macro: BEAM_META_POPCOUNT_EN.
module beam_meta_window_builder #(
    parameter int NBEAMS     = 48,
    parameter int NMETA      = 8,
    parameter int WINDOW     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         trig_i,
    input  logic [NBEAMS-1:0]            beam_i,
    input  logic                         mask_wr_i,
    input  logic [$clog2(NMETA)-1:0]     mask_addr_i,
    input  logic [NBEAMS-1:0]            mask_dat_i,
    output logic [NMETA-1:0]             meta_o,
    output logic [$clog2(NBEAMS+1)-1:0]  pop_o,
    output logic                         meta_valid_o,
    input  logic                         meta_ready_i,
    output logic [15:0]                  merge_cnt_o,
    output logic                         ovf_o,
    input  logic                         stat_clr_i
);
    localparam int AW = $clog2(NMETA);
    localparam int PW = $clog2(NBEAMS + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  WIN_M1 = 8'(WINDOW - 1);
    localparam logic [FW:0] FULL_CNT = (FW + 1)'(FIFO_DEPTH);

    // state | meaning
    // IDLE  | waiting for trig_i
    // ACCUM | window open: acc ORs beam_i, cnt counts down to 1
    // MAP   | acc mapped through masks, result pushed into the FIFO
    typedef enum logic [1:0] {IDLE, ACCUM, MAP} state_t;

    state_t             state;
    logic [NBEAMS-1:0]  acc;
    logic [7:0]         cnt;
    logic [NBEAMS-1:0]  mask [NMETA];
    logic [NMETA-1:0]   map_meta;
    logic               addr_ok;

    logic [NMETA-1:0]   fifo_meta [FIFO_DEPTH];
    logic [FW-1:0]      wr_ptr;
    logic [FW-1:0]      rd_ptr;
    logic [FW:0]        count;
    logic               valid;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;
    logic               merge_inc;

    generate
        if (NMETA == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_cmp
            assign addr_ok = int'(mask_addr_i) < NMETA;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_i) begin
                        acc   <= beam_i;
                        cnt   <= WIN_M1;
                        state <= (WINDOW == 1) ? MAP : ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc | beam_i;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= MAP;
                end
                MAP: begin
                    // a trigger here starts the next window without passing through IDLE
                    if (trig_i) begin
                        acc   <= beam_i;
                        cnt   <= WIN_M1;
                        state <= (WINDOW == 1) ? MAP : ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int j = 0; j < NMETA; j++) mask[j] <= '0;
        end else if (mask_wr_i && addr_ok) begin
            mask[mask_addr_i] <= mask_dat_i;
        end
    end

    always_comb begin
        map_meta = '0;
        for (int j = 0; j < NMETA; j++) map_meta[j] = |(acc & mask[j]);
    end

    assign valid     = (count != '0);
    assign push      = (state == MAP);
    assign pop       = valid & meta_ready_i;
    assign full      = (count == FULL_CNT);
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign merge_inc = (state == ACCUM) & trig_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) fifo_meta[wr_ptr] <= map_meta;
    end

    assign meta_o       = valid ? fifo_meta[rd_ptr] : '0;
    assign meta_valid_o = valid;

`ifdef BEAM_META_POPCOUNT_EN
    logic [PW-1:0] map_pop;
    logic [PW-1:0] fifo_pop [FIFO_DEPTH];

    always_comb begin
        map_pop = '0;
        for (int i = 0; i < NBEAMS; i++) map_pop = map_pop + PW'(acc[i]);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) fifo_pop[wr_ptr] <= map_pop;
    end

    assign pop_o = valid ? fifo_pop[rd_ptr] : '0;
`else
    assign pop_o = '0;
`endif

    // clear wins over a same-cycle increment or overflow
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            merge_cnt_o <= '0;
            ovf_o       <= 1'b0;
        end else if (stat_clr_i) begin
            merge_cnt_o <= '0;
            ovf_o       <= 1'b0;
        end else begin
            if (merge_inc && (merge_cnt_o != 16'hFFFF)) merge_cnt_o <= merge_cnt_o + 16'd1;
            if (drop) ovf_o <= 1'b1;
        end
    end

endmodule
